// File: rtl/inst_fetch_if.sv
// Instruction fetch bus bundle.
// Groups every non-clock signal of the fetch stage:
//   - Control from the core: Start, Stall, Branch, BrTaken and BrIdx.
//   - Branch-target LUT load port: lut_we, lut_waddr and lut_wdata.
//   - Instruction memory port: imem_addr out, imem_data back.
//   - Decoder-facing results: mach_code, pc_out, valid and Done.
// The fetch stage takes the master view. The surrounding core or bench
// takes the slave view.
interface inst_fetch_if #(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 16
);
  localparam int IDX_W = $clog2(LUT_DEPTH);

  logic             Start;
  logic             Stall;
  logic             Branch;
  logic             BrTaken;
  logic [IDX_W-1:0] BrIdx;
  logic             lut_we;
  logic [IDX_W-1:0] lut_waddr;
  logic [PC_W-1:0]  lut_wdata;
  logic [PC_W-1:0]  imem_addr;
  logic [8:0]       imem_data;
  logic [8:0]       mach_code;
  logic [PC_W-1:0]  pc_out;
  logic             valid;
  logic             Done;

  modport master (
    input  Start, Stall, Branch, BrTaken, BrIdx,
    input  lut_we, lut_waddr, lut_wdata,
    input  imem_data,
    output imem_addr, mach_code, pc_out, valid, Done
  );

  modport slave (
    output Start, Stall, Branch, BrTaken, BrIdx,
    output lut_we, lut_waddr, lut_wdata,
    output imem_data,
    input  imem_addr, mach_code, pc_out, valid, Done
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage.
// Owns the program counter and the branch-target LUT. It addresses
// instruction memory and registers the returned 9-bit machine code for the
// decoder.
// Ports:
//   Clk      rising-edge clock
//   Reset_n  asynchronous active-low reset (LUT contents survive it)
//   bus      inst_fetch_if master view: Start/Stall/Branch control,
//            LUT write port, imem address/data, and mach_code/pc_out/
//            valid/Done toward the decoder
module inst_fetch #(
  parameter int         PC_W      = 10,
  parameter int         LUT_DEPTH = 16,
  parameter logic [8:0] HALT_CODE = 9'h1FF
) (
  input  logic            Clk,
  input  logic            Reset_n,
  inst_fetch_if.master    bus
);

  localparam int IDX_W = $clog2(LUT_DEPTH);
  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } stateT;

  stateT           state, stateNext;
  logic [PC_W-1:0] pc, pcNext;
  logic [PC_W-1:0] pcOutReg, pcOutNext;
  logic [8:0]      machCode, machCodeNext;
  logic            validReg, validNext;
  logic            doneReg, doneNext;
  logic            armed, armedNext;

  logic [PC_W-1:0] lut [LUT_DEPTH];
  logic [PC_W-1:0] lutTarget;

  // Combinational LUT read. A write to the same entry in the same cycle
  // lands only at the edge, so a redirect still sees the old target.
  assign lutTarget = lut[bus.BrIdx];

  // Branch-target table, loaded by the program loader in any state.
  // It is deliberately left out of reset.
  always_ff @(posedge Clk) begin
    if (bus.lut_we) begin
      lut[bus.lut_waddr] <= bus.lut_wdata;
    end
  end

  // State and datapath registers. Everything except the LUT clears on reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      pc       <= '0;
      pcOutReg <= '0;
      machCode <= '0;
      validReg <= 1'b0;
      doneReg  <= 1'b0;
      armed    <= 1'b0;
    end else begin
      state    <= stateNext;
      pc       <= pcNext;
      pcOutReg <= pcOutNext;
      machCode <= machCodeNext;
      validReg <= validNext;
      doneReg  <= doneNext;
      armed    <= armedNext;
    end
  end

  // Next-state and datapath decisions.
  // IDLE waits for Start to rise and then fall. RUN fetches one word per
  // unstalled cycle. In RUN, Start beats stall, stall beats halt, and halt
  // beats a taken branch. When a halt or a redirect fires, the word being
  // fetched in that cycle is still captured, but it is marked as a bubble.
  always_comb begin
    stateNext    = state;
    pcNext       = pc;
    pcOutNext    = pcOutReg;
    machCodeNext = machCode;
    validNext    = validReg;
    doneNext     = doneReg;
    armedNext    = armed;

    case (state)
      IDLE: begin
        validNext = 1'b0;
        doneNext  = 1'b0;
        if (bus.Start) begin
          pcNext    = '0;
          armedNext = 1'b1;
        end else if (armed) begin
          stateNext = RUN;
          armedNext = 1'b0;
        end
      end

      RUN: begin
        if (bus.Start) begin
          stateNext = IDLE;
          pcNext    = '0;
          armedNext = 1'b1;
          validNext = 1'b0;
          doneNext  = 1'b0;
        end else if (!bus.Stall) begin
          machCodeNext = bus.imem_data;
          pcOutNext    = pc;
          if (validReg && (machCode == HALT_CODE)) begin
            stateNext = HALT;
            doneNext  = 1'b1;
            validNext = 1'b0;
            pcNext    = pc + PC_ONE;
          end else if (validReg && bus.Branch && bus.BrTaken) begin
            pcNext    = lutTarget;
            validNext = 1'b0;
          end else begin
            pcNext    = pc + PC_ONE;
            validNext = 1'b1;
          end
        end
      end

      HALT: begin
        validNext = 1'b0;
        doneNext  = 1'b1;
        if (bus.Start) begin
          stateNext = IDLE;
          doneNext  = 1'b0;
          pcNext    = '0;
          armedNext = 1'b1;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign bus.imem_addr = pc;
  assign bus.mach_code = machCode;
  assign bus.pc_out    = pcOutReg;
  assign bus.valid     = validReg;
  assign bus.Done      = doneReg;

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage directly upstream of the operand-select decoder.
- Owns the program counter and the branch-target lookup table.
- Addresses instruction memory and registers the 9-bit machine code that the decoder and control unit consume.
- Handles the Start/Done program handshake, stalls, taken-branch redirect with a one-cycle squash, and halt detection.

Parameters:
- PC_W, 10, program counter width; instruction memory holds 2^PC_W words.
- LUT_DEPTH, 16, number of branch-target LUT entries; index width is log2(LUT_DEPTH).
- HALT_CODE, 9'h1FF, machine code that terminates the program.

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- Start  in  1  held high to arm the core; falling edge launches the program.
- Stall  in  1  freezes the fetch stage (data-memory wait).
- Branch  in  1  the instruction in mach_code is a branch.
- BrTaken  in  1  branch condition true (from ALU), same cycle as Branch.
- BrIdx  in  log2(LUT_DEPTH)  LUT index selected by the branch instruction.
- lut_we  in  1  LUT write enable (program load).
- lut_waddr  in  log2(LUT_DEPTH)  LUT write index.
- lut_wdata  in  PC_W  absolute target written to the LUT.
- imem_addr  out  PC_W  instruction memory address; equals PC.
- imem_data  in  9  combinational read data at imem_addr.
- mach_code  out  9  registered instruction to the decoder.
- pc_out  out  PC_W  address of the instruction in mach_code.
- valid  out  1  mach_code is a live instruction; 0 means bubble.
- Done  out  1  program halted.

Behaviour:
- Reset (Reset_n low, asynchronous): state=IDLE, PC=0, mach_code=0, pc_out=0, valid=0, Done=0, armed=0. LUT contents are not reset.
- States: IDLE, RUN, HALT.
- IDLE:
  - Start=1: PC<=0, armed<=1, valid=0.
  - Start=0 with armed=1: go to RUN, armed<=0.
  - Start never seen: stay in IDLE.
- RUN, with Stall=0, each cycle:
  - mach_code<=imem_data, pc_out<=PC, valid<=1.
  - PC<=PC+1, wrapping modulo 2^PC_W.
- Redirect: valid=1 && Branch && BrTaken in RUN with Stall=0:
  - PC<=LUT[BrIdx].
  - The word fetched this cycle is squashed: mach_code<=imem_data, but valid<=0.
  - Exactly one bubble per taken branch. Branch with BrTaken=0 behaves as sequential.
- Branch/BrTaken are ignored when valid=0.
- Stall=1: PC, mach_code, pc_out and valid all hold. A Branch in the same cycle is ignored; stall wins, and the redirect is taken on the first unstalled cycle since the inputs persist.
- Halt:
  - Trigger: valid=1 && mach_code==HALT_CODE && Stall=0 in RUN.
  - Next cycle: state=HALT, Done=1, valid=0, PC frozen.
  - Halt takes priority over Branch.
- HALT: Done stays 1. Start=1 returns to IDLE, clears Done, sets PC=0 and armed=1.
- Start=1 during RUN aborts to IDLE with the same effects, next cycle.
- Latency: imem_data appears on mach_code one cycle after PC addresses it. The first valid instruction (address 0) appears on mach_code one cycle after the RUN-entry edge (two cycles after Start falls).
- LUT:
  - Synchronous write, in any state.
  - Combinational read.
  - Write and redirect to the same index in the same cycle: the redirect uses the old value.

Test Plan:
- Basic launch: reset; Start high 2 cycles then low; imem[0..3]=9'h010,9'h021,9'h032,9'h1FF -> mach_code/pc_out sequence 010/0, 021/1, 032/2, 1FF/3; Done=1 the next cycle, valid=0, PC frozen at 5.
- Taken branch: LUT[3]=10'd20; instruction at pc 1 with Branch=1, BrTaken=1, BrIdx=3 -> next cycle valid=0 (pc 2 squashed); following cycle pc_out=20, valid=1.
- Not-taken and stall: Branch=1, BrTaken=0 -> pc_out sequential, no bubble. Stall=1 for 3 cycles with Branch=1, BrTaken=1 -> mach_code/pc_out held; redirect occurs on the first unstalled cycle.
- Wrap-around: LUT[0]=10'd1022; branch to it with non-halt code at 1022, 1023, 0 -> pc_out 1022, 1023, 0.
- Abort and restart: Start=1 mid-RUN -> IDLE, valid=0, PC=0. In HALT, Start pulse -> Done=0, re-execution from pc 0.
- Async reset: Reset_n low mid-cycle during RUN -> all outputs 0 immediately without a clock edge; LUT contents retained.
